// File: rtl/cmd_frame_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmd_frame_rx_pkg : sync bytes, parser states and helpers shared by  |
// | the command frame receiver and the UART command writer. Rev 1.0     |
// +--------------------------------------------------------------------+
package cmd_frame_rx_pkg;

   localparam int c_DEF_MAX_LEN = 16;

   localparam logic [7:0] c_SYNC_0 = 8'hAA;
   localparam logic [7:0] c_SYNC_1 = 8'h99;
   localparam logic [7:0] c_SYNC_2 = 8'h55;
   localparam logic [7:0] c_SYNC_3 = 8'h66;

   typedef logic [2:0] state_t;

   localparam state_t c_ST_HUNT = 3'd0;
   localparam state_t c_ST_CMD  = 3'd1;
   localparam state_t c_ST_TAG  = 3'd2;
   localparam state_t c_ST_LEN  = 3'd3;
   localparam state_t c_ST_PAY  = 3'd4;
   localparam state_t c_ST_CSUM = 3'd5;
   localparam state_t c_ST_HOLD = 3'd6;

   function automatic logic [7:0] sync_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return c_SYNC_0;
         2'd1:    return c_SYNC_1;
         2'd2:    return c_SYNC_2;
         default: return c_SYNC_3;
      endcase
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A one-entry buffer still needs a one-bit read index.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_frame_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmd_frame_rx_if : byte input, frame handshake, payload read port    |
// | and error counters of the command frame receiver. Rev 1.0           |
// +--------------------------------------------------------------------+
interface cmd_frame_rx_if #(
   parameter int MAX_LEN = cmd_frame_rx_pkg::c_DEF_MAX_LEN
);
   localparam int IDX_W = cmd_frame_rx_pkg::idx_width(MAX_LEN);

   logic             rx_valid;
   logic [7:0]       rx_data;
   logic             frm_valid;
   logic             frm_ready;
   logic [7:0]       frm_cmd;
   logic [7:0]       frm_tag;
   logic [7:0]       frm_len;
   logic [IDX_W-1:0] frm_rd_idx;
   logic [7:0]       frm_rd_data;
   logic [7:0]       csum_err_cnt;
   logic [7:0]       len_err_cnt;
   logic [7:0]       tmo_cnt;
   logic [7:0]       drop_cnt;

   modport master (
      output rx_valid, rx_data, frm_ready, frm_rd_idx,
      input  frm_valid, frm_cmd, frm_tag, frm_len, frm_rd_data,
             csum_err_cnt, len_err_cnt, tmo_cnt, drop_cnt
   );

   modport slave (
      input  rx_valid, rx_data, frm_ready, frm_rd_idx,
      output frm_valid, frm_cmd, frm_tag, frm_len, frm_rd_data,
             csum_err_cnt, len_err_cnt, tmo_cnt, drop_cnt
   );

endinterface
`default_nettype wire

// File: rtl/cmd_frame_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmd_frame_buf : DEPTH x 8 register-file payload store, one write    |
// | port and a combinational read port. Rev 1.0                         |
// +--------------------------------------------------------------------+
module cmd_frame_buf #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [7:0]       i_wdata,
   input  logic [IDX_W-1:0] i_raddr,
   output logic [7:0]       o_rdata
);
   localparam logic [IDX_W:0] c_DEPTH = (IDX_W + 1)'(DEPTH);

   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Indices past the last entry exist when DEPTH is not a power of two.
   assign o_rdata = ({1'b0, i_raddr} < c_DEPTH) ? r_mem[i_raddr] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/cmd_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmd_frame_rx : hunts AA 99 55 66, parses CMD TAG LEN payload CSUM,  |
// | holds checked frames until consumed, counts errors. Rev 1.0         |
// +--------------------------------------------------------------------+
module cmd_frame_rx
   import cmd_frame_rx_pkg::*;
#(
   parameter int MAX_LEN     = c_DEF_MAX_LEN,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic          clk,
   input  logic          rst_b,
   cmd_frame_rx_if.slave bus
);
   localparam int IDX_W = idx_width(MAX_LEN);
   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [7:0]       c_MAX_LEN8 = 8'(MAX_LEN);
   localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [TMO_W-1:0] c_TMO_ONE  = TMO_W'(1);

   state_t           r_state;
   logic [1:0]       r_sync_idx;
   logic [7:0]       r_sum;
   logic [7:0]       r_cnt;
   logic [TMO_W-1:0] r_idle;
   logic [7:0]       r_cmd;
   logic [7:0]       r_tag;
   logic [7:0]       r_len;
   logic             r_valid;
   logic [7:0]       r_csum_err;
   logic [7:0]       r_len_err;
   logic [7:0]       r_tmo;
   logic [7:0]       r_drop;

   logic             w_in_frame;
   logic             w_we;
   logic [IDX_W-1:0] w_waddr;

   assign w_in_frame = (r_state != c_ST_HUNT) && (r_state != c_ST_HOLD);
   assign w_we       = bus.rx_valid && (r_state == c_ST_PAY);
   assign w_waddr    = r_cnt[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state    <= c_ST_HUNT;
         r_sync_idx <= 2'd0;
         r_sum      <= 8'h00;
         r_cnt      <= 8'h00;
         r_idle     <= '0;
         r_cmd      <= 8'h00;
         r_tag      <= 8'h00;
         r_len      <= 8'h00;
         r_valid    <= 1'b0;
         r_csum_err <= 8'h00;
         r_len_err  <= 8'h00;
         r_tmo      <= 8'h00;
         r_drop     <= 8'h00;
      end else begin
         if (bus.rx_valid) begin
            r_idle <= '0;
         end
         case (r_state)
            c_ST_HUNT: begin
               if (bus.rx_valid) begin
                  if (bus.rx_data == sync_byte(r_sync_idx)) begin
                     if (r_sync_idx == 2'd3) begin
                        r_state    <= c_ST_CMD;
                        r_sync_idx <= 2'd0;
                     end else begin
                        r_sync_idx <= r_sync_idx + 2'd1;
                     end
                  end else begin
                     // A stray AA may itself open the next header.
                     r_sync_idx <= (bus.rx_data == c_SYNC_0) ? 2'd1 : 2'd0;
                  end
               end
            end
            c_ST_CMD: begin
               if (bus.rx_valid) begin
                  r_cmd   <= bus.rx_data;
                  r_sum   <= bus.rx_data;
                  r_state <= c_ST_TAG;
               end
            end
            c_ST_TAG: begin
               if (bus.rx_valid) begin
                  r_tag   <= bus.rx_data;
                  r_sum   <= r_sum + bus.rx_data;
                  r_state <= c_ST_LEN;
               end
            end
            c_ST_LEN: begin
               if (bus.rx_valid) begin
                  if (bus.rx_data > c_MAX_LEN8) begin
                     r_len_err <= sat_inc(r_len_err);
                     r_state   <= c_ST_HUNT;
                  end else begin
                     r_len   <= bus.rx_data;
                     r_sum   <= r_sum + bus.rx_data;
                     r_cnt   <= 8'h00;
                     r_state <= (bus.rx_data == 8'h00) ? c_ST_CSUM : c_ST_PAY;
                  end
               end
            end
            c_ST_PAY: begin
               if (bus.rx_valid) begin
                  r_sum <= r_sum + bus.rx_data;
                  r_cnt <= r_cnt + 8'd1;
                  if (r_cnt == r_len - 8'd1) begin
                     r_state <= c_ST_CSUM;
                  end
               end
            end
            c_ST_CSUM: begin
               if (bus.rx_valid) begin
                  if (bus.rx_data == r_sum) begin
                     r_valid <= 1'b1;
                     r_state <= c_ST_HOLD;
                  end else begin
                     r_csum_err <= sat_inc(r_csum_err);
                     r_state    <= c_ST_HUNT;
                  end
               end
            end
            c_ST_HOLD: begin
               if (bus.rx_valid) begin
                  r_drop <= sat_inc(r_drop);
               end
               if (bus.frm_ready) begin
                  r_valid <= 1'b0;
                  r_state <= c_ST_HUNT;
               end
            end
            default: begin
               r_state <= c_ST_HUNT;
            end
         endcase
         if (!bus.rx_valid && w_in_frame) begin
            if (r_idle == c_TMO_LAST) begin
               r_idle  <= '0;
               r_tmo   <= sat_inc(r_tmo);
               r_state <= c_ST_HUNT;
            end else begin
               r_idle <= r_idle + c_TMO_ONE;
            end
         end
      end
   end

   cmd_frame_buf #(
      .DEPTH (MAX_LEN),
      .IDX_W (IDX_W)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (bus.rx_data),
      .i_raddr (bus.frm_rd_idx),
      .o_rdata (bus.frm_rd_data)
   );

   assign bus.frm_valid    = r_valid;
   assign bus.frm_cmd      = r_cmd;
   assign bus.frm_tag      = r_tag;
   assign bus.frm_len      = r_len;
   assign bus.csum_err_cnt = r_csum_err;
   assign bus.len_err_cnt  = r_len_err;
   assign bus.tmo_cnt      = r_tmo;
   assign bus.drop_cnt     = r_drop;

endmodule
`default_nettype wire

// File: doc/cmd_frame_rx.md
CMD_FRAME_RX -- requirements
Module: cmd_frame_rx

Interface
REQ-001 Parameter MAX_LEN, default 16: payload buffer depth in bytes; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYC, default 50000: idle clk cycles between bytes (1 ms at 50 MHz) before an open frame is abandoned.
REQ-003 clk  in  1  system clock (clk50m domain); one clock; all logic on its rising edge.
REQ-004 rst_b  in  1  synchronous, active-low reset.
REQ-005 rx_valid  in  1  one-cycle strobe: rx_data holds a byte received by the UART.
REQ-006 rx_data  in  8  received UART byte.
REQ-007 frm_valid  out  1  a checked frame is held and ready to be consumed.
REQ-008 frm_ready  in  1  consumer accepts the frame; the handshake completes when frm_valid and frm_ready are both high.
REQ-009 frm_cmd  out  8  command byte.
REQ-010 frm_tag  out  8  tag/device byte.
REQ-011 frm_len  out  8  payload byte count.
REQ-012 frm_rd_idx  in  clog2(MAX_LEN)  payload read index.
REQ-013 frm_rd_data  out  8  payload byte at frm_rd_idx; combinational read; value is undefined when idx >= frm_len.
REQ-014 csum_err_cnt, len_err_cnt, tmo_cnt, drop_cnt  out  8 each  saturating error counters.

Function
REQ-015 Frame format: sync AA 99 55 66, then CMD, TAG, LEN, then LEN payload bytes, then CSUM.
REQ-016 Checksum: CSUM equals the modulo-256 sum of CMD, TAG, LEN and all payload bytes; sync bytes are excluded.
REQ-017 States: HUNT (sync index 0..3), CMD, TAG, LEN, PAY, CSUM, HOLD; a state advances only on rx_valid.
REQ-018 HUNT, sync byte matches expected: the sync index increments; a match at index 3 goes to CMD.
REQ-019 HUNT, sync byte mismatches: the sync index becomes 1 if the byte is AA, otherwise 0. Sequence AA AA 99 55 66 therefore syncs.
REQ-020 LEN = 0: go straight to CSUM.
REQ-021 LEN > MAX_LEN: go to HUNT, increment len_err_cnt, write no payload.
REQ-022 PAY: write each byte to buffer[byte count]; after LEN bytes go to CSUM.
REQ-023 CSUM byte matches the running sum: go to HOLD and assert frm_valid on the next cycle (one cycle after the CSUM strobe).
REQ-024 CSUM byte mismatches: go to HUNT and increment csum_err_cnt.
REQ-025 HOLD: frm_valid stays high and frm_cmd/tag/len/buffer stay stable until the handshake. On the handshake cycle the block returns to HUNT with frm_valid low on the next cycle.
REQ-026 rx_valid during HOLD: the byte is discarded and drop_cnt increments. A byte arriving in the same cycle as the handshake is also dropped.
REQ-027 Idle counter: resets on every rx_valid and counts only in CMD..CSUM. When it reaches TIMEOUT_CYC, go to HUNT and increment tmo_cnt. HUNT and HOLD never time out.
REQ-028 Counters saturate at FF and never wrap. Counters are only cleared by reset.
REQ-029 frm_valid never asserts for a frame with a bad checksum, a bad length or a timeout.

Reset
REQ-030 rst_b low at a clock edge puts the block in HUNT with sync index 0 and clears frm_valid, frm_cmd, frm_tag, frm_len, the running sum, the byte count, the idle counter and all error counters to 0.
REQ-031 Reset mid-frame or in HOLD discards the frame; the payload buffer contents need no reset.

Structure
REQ-032 Shared package holds the sync constants (AA, 99, 55, 66), the state enumeration and the MAX_LEN default; the UART command writer uses the same package.
REQ-033 One natural sub-module: cmd_frame_buf, the MAX_LEN x 8 register-file payload store with a write port and a combinational read port.

Verification
REQ-034 Send 02 00 03 00 00 20 25 with the sync header -> frm_valid one cycle after CSUM; cmd=02, tag=00, len=3, payload 00 00 20.
REQ-035 Send AA AA 99 55 66 01 33 04 00 34 77 F0 D3 -> frame accepted; cmd=01, len=4, payload 00 34 77 F0.
REQ-036 Send 02 00 03 01 20 18 with CSUM 3F instead of 3E -> no frm_valid, csum_err_cnt=1; the next good frame is accepted.
REQ-037 Send LEN=20 with MAX_LEN=16 -> len_err_cnt=1, block returns to HUNT; a following 16-byte frame is accepted.
REQ-038 Hold frm_ready low and send a second frame -> first frame stays stable, drop_cnt counts every byte of the second frame; raise frm_ready -> frm_valid low next cycle.
REQ-039 Stop mid-payload for TIMEOUT_CYC cycles -> tmo_cnt=1 and the parser is back in HUNT; pulse rst_b during PAY -> frm_valid stays 0 and all counters read 0.
